// File: rtl/rlc_onchip_mem_arb_if.sv
// One Avalon-MM slave port of the shared on-chip memory: command from the bus master,
// waitrequest and pipelined read response back.
interface rlc_onchip_mem_arb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16
);
   logic                  chipselect;
   logic                  read;
   logic                  write;
   logic [ADDR_W-1:0]     address;
   logic [DATA_W/8-1:0]   byteenable;
   logic [DATA_W-1:0]     writedata;
   logic                  waitrequest;
   logic [DATA_W-1:0]     readdata;
   logic                  readdatavalid;

   modport master (
      output chipselect, read, write, address, byteenable, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  chipselect, read, write, address, byteenable, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/rlc_onchip_mem_arb.sv
// Dual-slave on-chip RAM: s1 and s2 share one single-port array through a round-robin
// arbiter, with a tagged read pipeline and out-of-range protection.
module rlc_onchip_mem_arb #(
   parameter int    DATA_W       = 32,
   parameter int    ADDR_W       = 16,
   parameter int    DEPTH        = 50000,
   parameter int    READ_LATENCY = 1,
   parameter string INIT_FILE    = "RLC_game_system_onchip_mem.hex"
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clken,
   input  logic                reset_req,
   rlc_onchip_mem_arb_if.slave s1,
   rlc_onchip_mem_arb_if.slave s2,
   output logic [7:0]          oor_count
);
   localparam int BE_W = DATA_W / 8;
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   typedef struct packed {
      logic vld;
      logic port;   // 0 = s1, 1 = s2
      logic oor;
   } tag_t;

   logic                        stall;
   logic [1:0]                  req, gnt;
   logic                        last_grant_q, last_grant_d;
   logic                        g_port, g_write, g_oor, wr_en, rd_en, wr_oor, rd_oor;
   logic [ADDR_W-1:0]           g_addr;
   logic [AW-1:0]               g_idx;
   logic [BE_W-1:0]             g_be;
   logic [DATA_W-1:0]           g_wdata, last_data;
   tag_t                        tag_in, last_tag, out_tag;
   tag_t [READ_LATENCY:1]       tag_q;
   tag_t [READ_LATENCY:0]       tag_chain;
   logic [1:0][DATA_W-1:0]      rdata_q;
   logic [7:0]                  oor_q, oor_d;
   logic [8:0]                  oor_sum;

   // Contents are preloaded by the FPGA flow from INIT_FILE; reset never touches them.
   (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];

   assign stall = ~clken | reset_req;
   assign req   = {s2.chipselect & (s2.read | s2.write),
                   s1.chipselect & (s1.read | s1.write)};

   always_comb begin
      gnt = 2'b00;
      if (!stall) begin
         if (&req) gnt = last_grant_q ? 2'b01 : 2'b10;
         else      gnt = req;
      end
   end

   assign s1.waitrequest = req[0] & ~gnt[0];
   assign s2.waitrequest = req[1] & ~gnt[1];

   assign g_port  = gnt[1];
   assign g_addr  = g_port ? s2.address    : s1.address;
   assign g_be    = g_port ? s2.byteenable : s1.byteenable;
   assign g_wdata = g_port ? s2.writedata  : s1.writedata;
   assign g_write = g_port ? s2.write      : s1.write;
   assign g_oor   = {1'b0, g_addr} >= DEPTH_L;
   assign g_idx   = g_oor ? '0 : g_addr[AW-1:0];
   assign wr_en   = (|gnt) & g_write & ~g_oor & ~reset;
   assign rd_en   = (|gnt) & ~g_write;
   assign wr_oor  = (|gnt) & g_write & g_oor;

   assign tag_in    = '{vld: rd_en, port: g_port, oor: g_oor};
   assign tag_chain = {tag_q, tag_in};
   assign last_tag  = tag_chain[READ_LATENCY-1];
   assign out_tag   = tag_q[READ_LATENCY];
   // Out-of-range reads are counted as they leave the pipeline.
   assign rd_oor    = out_tag.vld & out_tag.oor;

   always_ff @(posedge clk) begin
      if (wr_en)
         for (int b = 0; b < BE_W; b++)
            if (g_be[b]) mem[g_idx][b*8 +: 8] <= g_wdata[b*8 +: 8];
   end

   generate
      if (READ_LATENCY == 2) begin : g_rl2
         logic [DATA_W-1:0] mid_q;
         always_ff @(posedge clk) begin
            if (!stall && rd_en) mid_q <= mem[g_idx];
         end
         assign last_data = mid_q;
      end else begin : g_rl1
         assign last_data = mem[g_idx];
      end
   endgenerate

   always_comb begin
      last_grant_d = last_grant_q;
      if (|gnt) last_grant_d = g_port;
      oor_sum = {1'b0, oor_q} + 9'(wr_oor) + 9'(rd_oor);
      oor_d   = (oor_sum > 9'd255) ? 8'hFF : oor_sum[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= 1'b1;
         tag_q        <= '0;
         rdata_q      <= '0;
         oor_q        <= '0;
      end else if (!stall) begin
         last_grant_q <= last_grant_d;
         oor_q        <= oor_d;
         tag_q        <= tag_chain[READ_LATENCY-1:0];
         if (last_tag.vld)
            rdata_q[last_tag.port] <= last_tag.oor ? '0 : last_data;
      end
   end

   assign s1.readdata      = rdata_q[0];
   assign s2.readdata      = rdata_q[1];
   assign s1.readdatavalid = out_tag.vld & ~out_tag.port & ~stall;
   assign s2.readdatavalid = out_tag.vld &  out_tag.port & ~stall;
   assign oor_count        = oor_q;
endmodule

// File: tb/tb_rlc_onchip_mem_arb.sv
// Scoreboard bench: drives READ_LATENCY=1 and =2 instances with identical directed traffic.
module tb_rlc_onchip_mem_arb;
   logic clk = 1'b0, reset = 1'b1, clken = 1'b1, reset_req = 1'b0;
   logic [1:0]            cs = '0, rd = '0, wr = '0;
   logic [1:0][15:0]      addr = '0;
   logic [1:0][3:0]       be = '0;
   logic [1:0][31:0]      wd = '0, exp_d = '0;
   logic [1:0][1:0]       wq, rdv;
   logic [1:0][1:0][31:0] rdq;
   logic [1:0][7:0]       oor;
   int ntick = 0, n_tests = 0, n_fail = 0;
   logic stall_b;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   assign stall_b = !clken || reset_req;
   always #5 clk = ~clk;
   always @(posedge clk) if (!stall_b) ntick <= ntick + 1;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   for (genvar d = 0; d < 2; d++) begin : g_dut
      localparam int RL = d + 1;
      logic [7:0] oor_o;
      rlc_onchip_mem_arb_if #(.DATA_W(32), .ADDR_W(16)) sif [2] ();

      rlc_onchip_mem_arb #(.READ_LATENCY(RL)) u_dut (
         .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
         .s1(sif[0]), .s2(sif[1]), .oor_count(oor_o)
      );
      assign oor[d] = oor_o;

      for (genvar p = 0; p < 2; p++) begin : g_port
         exp_t q[$];
         assign sif[p].chipselect = cs[p];
         assign sif[p].read       = rd[p];
         assign sif[p].write      = wr[p];
         assign sif[p].address    = addr[p];
         assign sif[p].byteenable = be[p];
         assign sif[p].writedata  = wd[p];
         assign wq[d][p]  = sif[p].waitrequest;
         assign rdv[d][p] = sif[p].readdatavalid;
         assign rdq[d][p] = sif[p].readdata;

         // A granted read expects its data RL non-stalled cycles after the grant edge.
         always @(posedge clk) begin
            if (reset) q.delete();
            else if (!stall_b && cs[p] && rd[p] && !wr[p] && !wq[d][p])
               q.push_back('{exp_d[p], ntick + RL});
         end

         always @(negedge clk) begin
            exp_t e;
            if (rdv[d][p] === 1'b1) begin
               if (q.size() == 0 || stall_b) begin
                  n_tests++; n_fail++;
                  $display("FAIL rsp_unexpected rl%0d s%0d: got readdatavalid=1, expected 0", RL, p+1);
               end else begin
                  e = q.pop_front();
                  chk($sformatf("rsp_data rl%0d s%0d", RL, p+1), rdq[d][p], e.data);
                  chk($sformatf("rsp_cycle rl%0d s%0d", RL, p+1), ntick, e.due);
               end
            end else if (!stall_b && q.size() > 0 && q[0].due <= ntick) begin
               n_tests++; n_fail++;
               $display("FAIL rsp_missing rl%0d s%0d: got readdatavalid=0, expected 1 with %h",
                        RL, p+1, q[0].data);
               q.delete(0);
            end
         end
      end
   end

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cs = '0; rd = '0; wr = '0;
   endtask

   // Single-port access held until accepted; for reads, data is the expected word.
   task automatic acc(int p, bit w, int a, logic [3:0] b, logic [31:0] data);
      bit ok = 1'b0;
      idle();
      cs[p] = 1'b1; rd[p] = !w; wr[p] = w;
      addr[p] = a[15:0]; be[p] = b; wd[p] = data; exp_d[p] = data;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = !stall_b && !wq[0][p];
         @(posedge clk); #1;
      end
      if (!ok) begin
         n_tests++; n_fail++;
         $display("FAIL accept_timeout s%0d: not granted, expected grant within 20 cycles", p+1);
      end
   endtask

   task automatic stall_test(bit use_req);
      acc(0, 1, 5, 4'hF, 32'h0000_0055);
      acc(0, 0, 5, 4'hF, 32'h0000_0055);
      idle();
      if (use_req) reset_req = 1'b1; else clken = 1'b0;
      cs[1] = 1'b1; rd[1] = 1'b1; addr[1] = 16'd10; exp_d[1] = 32'hAA22_CC44;
      repeat (3) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++)
            chk($sformatf("stall_waitreq rl%0d req=%0d", d+1, use_req), 32'(wq[d][1]), 32'd1);
         @(posedge clk); #1;
      end
      clken = 1'b1; reset_req = 1'b0;
      acc(1, 0, 10, 4'hF, 32'hAA22_CC44);
      idle();
      cyc(4);
   endtask

   initial begin
      cyc(2);
      reset = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset_oor rl%0d", d+1), 32'(oor[d]), 32'd0);
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("reset_rdata rl%0d s%0d", d+1, p+1), rdq[d][p], 32'd0);
            chk($sformatf("reset_rdv rl%0d s%0d", d+1, p+1), 32'(rdv[d][p]), 32'd0);
            chk($sformatf("reset_waitreq rl%0d s%0d", d+1, p+1), 32'(wq[d][p]), 32'd0);
         end
      end
      @(posedge clk); #1;

      // Preload, then back-to-back reads of 0..3 on s1
      for (int i = 0; i < 4; i++) acc(0, 1, i, 4'hF, 32'h1000_0000 + i);
      for (int i = 0; i < 3; i++) begin
         acc(0, 1, 20 + i, 4'hF, 32'h2000_0000 + i);
         acc(1, 1, 30 + i, 4'hF, 32'h3000_0000 + i);
      end
      for (int i = 0; i < 4; i++) acc(0, 0, i, 4'hF, 32'h1000_0000 + i);
      idle(); cyc(4);

      // Byte enables plus read-after-write on the next cycle
      acc(1, 1, 10, 4'hF, 32'hAABB_CCDD);
      acc(1, 1, 10, 4'b0101, 32'h1122_3344);
      acc(1, 0, 10, 4'hF, 32'hAA22_CC44);
      idle(); cyc(4);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rdata_hold rl%0d", d+1), rdq[d][1], 32'hAA22_CC44);
         chk($sformatf("rdv_idle rl%0d", d+1), 32'(rdv[d][1]), 32'd0);
      end
      @(posedge clk); #1;

      stall_test(1'b0);
      stall_test(1'b1);

      // Out of range: one write, one read, then saturation
      acc(0, 1, 50000, 4'hF, 32'hDEAD_BEEF);
      acc(0, 0, 50001, 4'hF, 32'h0000_0000);
      idle(); cyc(4);
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk($sformatf("oor_two rl%0d", d+1), 32'(oor[d]), 32'd2);
      @(posedge clk); #1;
      acc(0, 0, 0, 4'hF, 32'h1000_0000);
      for (int i = 0; i < 298; i++) acc(1, 1, 50000 + (i % 1000), 4'hF, 32'(i));
      idle(); cyc(3);
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk($sformatf("oor_sat rl%0d", d+1), 32'(oor[d]), 32'd255);
      @(posedge clk); #1;

      // Reset with a read in flight; the same-cycle write must be dropped
      acc(0, 0, 1, 4'hF, 32'h1000_0001);
      reset = 1'b1;
      idle();
      cs[1] = 1'b1; wr[1] = 1'b1; addr[1] = 16'd0; be[1] = 4'hF; wd[1] = 32'hBAD0_BAD0;
      cyc(1);
      reset = 1'b0;
      idle();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_oor rl%0d", d+1), 32'(oor[d]), 32'd0);
         chk($sformatf("rst_rdata rl%0d", d+1), rdq[d][0], 32'd0);
      end
      @(posedge clk); #1;
      cyc(2);

      // Both ports read continuously: s1 wins the first tie, then strict alternation
      begin
         int k1 = 0, k2 = 0;
         for (int k = 0; k < 6; k++) begin
            cs = 2'b11; rd = 2'b11; wr = 2'b00;
            addr[0] = 16'(20 + k1); addr[1] = 16'(30 + k2);
            exp_d[0] = 32'h2000_0000 + k1; exp_d[1] = 32'h3000_0000 + k2;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
               chk($sformatf("arb_wait_s1 rl%0d k%0d", d+1, k), 32'(wq[d][0]), 32'(k % 2));
               chk($sformatf("arb_wait_s2 rl%0d k%0d", d+1, k), 32'(wq[d][1]), 32'(1 - k % 2));
            end
            @(posedge clk); #1;
            if (k % 2 == 0) k1++; else k2++;
         end
      end
      idle(); cyc(4);

      acc(1, 0, 0, 4'hF, 32'h1000_0000);
      idle(); cyc(6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/rlc_onchip_mem_arb.md
# rlc_onchip_mem_arb

Parametrised dual-slave on-chip memory for the RLC game Qsys system, the successor to the fixed 32x50000 single-port RAM. Two Avalon-MM slaves (s1 for the Nios II data master, s2 for the VGA/DMA side) share one inferred single-port array through a round-robin arbiter. The block adds a configurable read latency with `readdatavalid` pipelining and out-of-range address protection.

## Interface
- `DATA_W`, 32: data width; multiple of 8.
- `ADDR_W`, 16: word address width.
- `DEPTH`, 50000: words implemented; ≤ 2^ADDR_W.
- `READ_LATENCY`, 1: grant-to-`readdatavalid` cycles; legal values 1 or 2.
- `INIT_FILE`, "RLC_game_system_onchip_mem.hex": array init file.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `clken` in 1: clock enable; 0 stalls the block.
- `reset_req` in 1: 1 stalls the block (reset-sequence protection).
- `sN_address` in ADDR_W: word address (N = 1, 2).
- `sN_chipselect`, `sN_read`, `sN_write` in 1: request qualifiers.
- `sN_byteenable` in DATA_W/8: write lane enables.
- `sN_writedata` in DATA_W: write data.
- `sN_waitrequest` out 1: command not accepted this cycle.
- `sN_readdata` out DATA_W: read data.
- `sN_readdatavalid` out 1: `sN_readdata` valid this cycle.
- `oor_count` out 8: saturating count of out-of-range accesses.

## Operation
- Request: `reqN = sN_chipselect & (sN_read | sN_write)`. When both are set, the access is a write only and returns no read data.
- Stall: `stall = ~clken | reset_req`. While stalled:
  - no grants are issued;
  - both waitrequests equal their reqN;
  - the read pipeline holds;
  - `readdatavalid` is 0.
- Arbitration (not stalled):
  - Only s1 requests: grant s1. Only s2 requests: grant s2.
  - Both request: grant the port not granted last.
  - `last_grant` updates on every grant and resets to s2, so s1 wins the first tie.
  - Losing port: `waitrequest = 1`, combinational from the requests and `last_grant`.
- Granted write, address < DEPTH: each enabled byte lane is written at the clock edge.
- Granted write, address ≥ DEPTH: write dropped; `oor_count` increments.
- Granted read: a tag {valid, port, oor} enters a READ_LATENCY-deep shift pipeline. Array data is registered at stage 1. READ_LATENCY = 2 adds one output register.
- Pipeline exit: the tagged port sees `readdatavalid = 1` and `readdata` = array word, or 0 if the tag has oor set. Out-of-range reads also increment `oor_count`.
- `readdata` holds its last value when `readdatavalid` is 0.
- Responses return in grant order. The single array port means there are no read/write collisions.
- `oor_count` saturates at 255.
- Memory contents are not affected by `reset`.

## Timing
- Reset values:
  - `sN_readdata` = 0, `sN_readdatavalid` = 0
  - `oor_count` = 0, `last_grant` = s2
  - all pipeline tags invalid
  - `waitrequest` follows the combinational rule
- Read: grant at edge T → `readdatavalid` high in cycle T+READ_LATENCY, counted only in non-stalled cycles. A stall of k cycles delays the response by k.
- Throughput: one access per non-stalled cycle, no bubbles, including back-to-back reads from alternating ports.
- Write: committed at the grant edge. A read granted at T+1 to the same address returns the new data.
- Reset with reads in flight: tags are cleared and no `readdatavalid` is emitted for those reads. Array writes in the same cycle as `reset` are suppressed.
- `reset` has priority over `stall`.

## Test plan
- Init and read: READ_LATENCY=1, s1 reads addresses 0..3 back-to-back → `s1_readdatavalid` high on 4 consecutive cycles starting 1 cycle after the first grant, data equal to INIT_FILE words 0..3; repeat with READ_LATENCY=2 → valid 2 cycles after grant.
- Byte enables: write 0xAABBCCDD at address 10, then write 0x11223344 with byteenable 4'b0101, then read → 0xAA22CC44.
- Arbitration: s1 and s2 read continuously for 6 cycles → grants alternate s1, s2, s1, …; each port has waitrequest high on alternate cycles; each port receives 3 responses in order.
- Stall: issue a read, drive clken=0 for 3 cycles in the next cycle → no `readdatavalid` during the stall, valid in the first cycle after clken returns; reset_req=1 behaves identically.
- Out of range: write to address 50000, then read address 50001 → memory unchanged, read returns 0 with valid, `oor_count` = 2; 300 out-of-range accesses → `oor_count` = 255.
- Reset mid-read: READ_LATENCY=2, grant a read, assert reset the next cycle → no `readdatavalid`, `readdata` = 0, `oor_count` = 0, next tie is won by s1.
